coefficient_store: RTL and testbench

Responder side of the FIR coefficient-load handshake. It holds four host-written staging coefficients and raises `new_coefficient_set` when the host requests a load. It answers each `load_coeff` pulse from the coefficient loader by copying the addressed staging word into the active coefficient bank, holding `modwait` high while the copy is in progress. It drops `new_coefficient_set` on `clear_new_coefficient` and flags `coeff_ready` once all four active slots have been refreshed.

---
 rtl/coeff_pkg.sv | 8 +
 rtl/coeff_regfile.sv | 36 +++
 rtl/coefficient_store.sv | 81 ++++++++
 tb/tb_coefficient_store.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/coeff_pkg.sv
// Shared constants and state encoding for the FIR coefficient store.
package coeff_pkg;
  localparam int COEFF_W   = 16;
  localparam int NUM_COEFF = 4;
  localparam logic [2:0] SEL_CTRL = 3'd4;

  typedef enum logic [1:0] {IDLE, STORE, SETTLE} store_state_t;
endpackage

// File: rtl/coeff_regfile.sv
// Staging and active coefficient banks; one staging write and one
// staging-to-active copy per cycle.
module coeff_regfile #(
  parameter int COEFF_W   = 16,
  parameter int NUM_COEFF = 4,
  parameter int IDX_W     = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_en,
  input  logic [IDX_W-1:0]             wr_idx,
  input  logic [COEFF_W-1:0]           wr_data,
  input  logic                         copy_en,
  input  logic [IDX_W-1:0]             copy_idx,
  output logic [NUM_COEFF*COEFF_W-1:0] active_out
);
  logic [NUM_COEFF-1:0][COEFF_W-1:0] staging;
  logic [NUM_COEFF-1:0][COEFF_W-1:0] active;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      staging <= '0;
      active  <= '0;
    end else begin
      for (int i = 0; i < NUM_COEFF; i++) begin
        if (wr_en && wr_idx == IDX_W'(i))
          staging[i] <= wr_data;
        // Copy reads the pre-write staging value if both hit the same slot.
        if (copy_en && copy_idx == IDX_W'(i))
          active[i] <= staging[i];
      end
    end
  end

  assign active_out = active;
endmodule

// File: rtl/coefficient_store.sv
// Responder side of the FIR coefficient-load handshake: load-request flag,
// store FSM driving modwait, refreshed-slot mask and protocol error pulse.
module coefficient_store #(
  parameter int COEFF_W   = coeff_pkg::COEFF_W,
  parameter int NUM_COEFF = coeff_pkg::NUM_COEFF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         host_wr_en,
  input  logic [2:0]                   host_wr_sel,
  input  logic [COEFF_W-1:0]           host_wdata,
  input  logic                         load_coeff,
  input  logic [1:0]                   coefficient_num,
  input  logic                         clear_new_coefficient,
  output logic                         new_coefficient_set,
  output logic                         modwait,
  output logic [NUM_COEFF*COEFF_W-1:0] coeff_out,
  output logic                         coeff_ready,
  output logic                         proto_err
);
  import coeff_pkg::*;

  store_state_t         state, state_nxt;
  logic [NUM_COEFF-1:0] loaded;
  logic                 stage_wr, start_req, do_start, copy_en;

  assign stage_wr  = host_wr_en && (host_wr_sel < SEL_CTRL);
  assign start_req = host_wr_en && (host_wr_sel == SEL_CTRL) && host_wdata[0];
  // A start landing with a clear re-arms the flag even if it is already set.
  assign do_start  = start_req && (!new_coefficient_set || clear_new_coefficient);
  assign copy_en   = (state == STORE);
  assign modwait   = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load_coeff) state_nxt = STORE;
      STORE:   state_nxt = SETTLE;
      SETTLE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      new_coefficient_set <= 1'b0;
      loaded              <= '0;
      coeff_ready         <= 1'b0;
      proto_err           <= 1'b0;
    end else begin
      if (do_start)                   new_coefficient_set <= 1'b1;
      else if (clear_new_coefficient) new_coefficient_set <= 1'b0;

      if (do_start)     loaded <= '0;
      else if (copy_en) loaded[coefficient_num] <= 1'b1;

      coeff_ready <= (&loaded) && !new_coefficient_set;
      proto_err   <= (load_coeff && state != IDLE) || (stage_wr && new_coefficient_set);
    end
  end

  coeff_regfile #(
    .COEFF_W   (COEFF_W),
    .NUM_COEFF (NUM_COEFF),
    .IDX_W     (2)
  ) u_regfile (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (stage_wr && !new_coefficient_set),
    .wr_idx     (host_wr_sel[1:0]),
    .wr_data    (host_wdata),
    .copy_en    (copy_en),
    .copy_idx   (coefficient_num),
    .active_out (coeff_out)
  );
endmodule

// File: tb/tb_coefficient_store.sv
// Directed bench for coefficient_store: stimulus schedules expected output
// values per cycle into a queue; a negedge monitor pops and compares them.
module tb_coefficient_store;
  logic        clk = 1'b0;
  logic        reset;
  logic        host_wr_en;
  logic [2:0]  host_wr_sel;
  logic [15:0] host_wdata;
  logic        load_coeff;
  logic [1:0]  coefficient_num;
  logic        clear_new_coefficient;
  logic        new_coefficient_set;
  logic        modwait;
  logic [63:0] coeff_out;
  logic        coeff_ready;
  logic        proto_err;

  coefficient_store dut (
    .clk                   (clk),
    .reset                 (reset),
    .host_wr_en            (host_wr_en),
    .host_wr_sel           (host_wr_sel),
    .host_wdata            (host_wdata),
    .load_coeff            (load_coeff),
    .coefficient_num       (coefficient_num),
    .clear_new_coefficient (clear_new_coefficient),
    .new_coefficient_set   (new_coefficient_set),
    .modwait               (modwait),
    .coeff_out             (coeff_out),
    .coeff_ready           (coeff_ready),
    .proto_err             (proto_err)
  );

  always #5 clk = ~clk;

  localparam int F_MW = 0, F_NCS = 1, F_COUT = 2, F_RDY = 3, F_PERR = 4;

  typedef struct {
    int          cyc;
    int          fld;
    logic [63:0] val;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [63:0] act;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] pick(input int f);
    case (f)
      F_MW:    return {63'd0, modwait};
      F_NCS:   return {63'd0, new_coefficient_set};
      F_COUT:  return coeff_out;
      F_RDY:   return {63'd0, coeff_ready};
      default: return {63'd0, proto_err};
    endcase
  endfunction

  // Monitor: compare every entry scheduled for the current cycle.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        act = pick(sb[i].fld);
        checks++;
        if (sb[i].cyc < cyc || act !== sb[i].val) begin
          errors++;
          $display("FAIL %s: got %0h expected %0h (cycle %0d)", sb[i].name, act, sb[i].val, cyc);
        end
        sb.delete(i);
      end
    end
  end

  task automatic push(input int c, input int f, input logic [63:0] v, input string n);
    exp_t e;
    e.cyc = c; e.fld = f; e.val = v; e.name = n;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [2:0] sel, input logic [15:0] d);
    host_wr_en = 1'b1; host_wr_sel = sel; host_wdata = d;
    tick();
    host_wr_en = 1'b0;
  endtask

  // Loader handshake: index 'pre' during the load_coeff cycle, 'idx' after.
  task automatic load_slot(input logic [1:0] pre, input logic [1:0] idx, input logic [63:0] exp_out);
    int c0;
    c0 = cyc;
    push(c0,     F_MW,   64'd0, "mw_before_load");
    push(c0 + 1, F_MW,   64'd1, "mw_store");
    push(c0 + 2, F_MW,   64'd1, "mw_settle");
    push(c0 + 3, F_MW,   64'd0, "mw_done");
    push(c0 + 2, F_COUT, exp_out, "coeff_out_after_store");
    load_coeff = 1'b1; coefficient_num = pre;
    tick();
    load_coeff = 1'b0; coefficient_num = idx;
    tick(); tick(); tick();
  endtask

  initial begin
    int c;
    reset = 1'b1; host_wr_en = 1'b0; host_wr_sel = 3'd0; host_wdata = 16'd0;
    load_coeff = 1'b0; coefficient_num = 2'd0; clear_new_coefficient = 1'b0;

    // Reset state
    tick(); tick();
    c = cyc;
    push(c, F_MW, 64'd0, "rst_modwait");
    push(c, F_NCS, 64'd0, "rst_ncs");
    push(c, F_COUT, 64'd0, "rst_coeff_out");
    push(c, F_RDY, 64'd0, "rst_ready");
    push(c, F_PERR, 64'd0, "rst_perr");
    tick();
    reset = 1'b0;
    tick();

    // Stage 1..4, start, full loader sequence, clear
    host_write(3'd0, 16'h0001);
    host_write(3'd1, 16'h0002);
    host_write(3'd2, 16'h0003);
    host_write(3'd3, 16'h0004);
    c = cyc;
    push(c, F_NCS, 64'd0, "ncs_before_start");
    push(c + 1, F_NCS, 64'd1, "ncs_after_start");
    push(c + 1, F_PERR, 64'd0, "perr_clean_start");
    host_write(3'd4, 16'h0001);
    tick();
    load_slot(2'd0, 2'd0, 64'h0000_0000_0000_0001);
    load_slot(2'd1, 2'd1, 64'h0000_0000_0002_0001);
    load_slot(2'd2, 2'd2, 64'h0000_0003_0002_0001);
    load_slot(2'd3, 2'd3, 64'h0004_0003_0002_0001);
    c = cyc;
    push(c, F_RDY, 64'd0, "ready_blocked_by_ncs");
    push(c, F_NCS, 64'd1, "ncs_before_clear");
    push(c + 1, F_NCS, 64'd0, "ncs_after_clear");
    push(c + 1, F_RDY, 64'd0, "ready_m1");
    push(c + 2, F_RDY, 64'd1, "ready_m2");
    clear_new_coefficient = 1'b1;
    tick();
    clear_new_coefficient = 1'b0;
    tick(); tick();

    // Index changes 3 -> 1 after load_coeff: slot 1 stored, slot 3 untouched
    host_write(3'd1, 16'h1111);
    host_write(3'd3, 16'h3333);
    push(cyc, F_PERR, 64'd0, "perr_idle_writes");
    load_slot(2'd3, 2'd1, 64'h0004_0003_1111_0001);

    // load_coeff during STORE is ignored and flagged
    c = cyc;
    load_coeff = 1'b1; coefficient_num = 2'd0;
    tick();
    load_coeff = 1'b1; coefficient_num = 2'd3;
    push(c + 1, F_PERR, 64'd0, "perr_store_cycle");
    push(c + 2, F_PERR, 64'd1, "perr_load_in_store");
    push(c + 3, F_PERR, 64'd0, "perr_one_cycle");
    push(c + 1, F_MW, 64'd1, "mw_overlap_c1");
    push(c + 2, F_MW, 64'd1, "mw_overlap_c2");
    push(c + 3, F_MW, 64'd0, "mw_overlap_c3");
    push(c + 2, F_COUT, 64'h3333_0003_1111_0001, "coeff_out_overlap");
    tick();
    load_coeff = 1'b0;
    tick(); tick();

    // Staging write while flag set is rejected; start+clear keeps flag
    host_write(3'd2, 16'h2222);
    c = cyc;
    push(c + 1, F_NCS, 64'd1, "ncs_restart");
    push(c + 1, F_RDY, 64'd1, "ready_until_restart");
    push(c + 2, F_RDY, 64'd0, "ready_after_restart");
    host_write(3'd4, 16'h0001);
    tick();
    c = cyc;
    push(c + 1, F_PERR, 64'd1, "perr_write_while_set");
    push(c + 2, F_PERR, 64'd0, "perr_write_one_cycle");
    host_write(3'd2, 16'hBEEF);
    tick();
    c = cyc;
    host_wr_en = 1'b1; host_wr_sel = 3'd4; host_wdata = 16'h0001;
    clear_new_coefficient = 1'b1;
    push(c + 1, F_NCS, 64'd1, "ncs_start_beats_clear");
    push(c + 2, F_NCS, 64'd1, "ncs_stays_set");
    push(c + 2, F_RDY, 64'd0, "ready_after_start_clear");
    tick();
    host_wr_en = 1'b0; clear_new_coefficient = 1'b0;
    tick();
    load_slot(2'd2, 2'd2, 64'h3333_2222_1111_0001);

    // Reset during STORE aborts the copy and clears the bank
    c = cyc;
    load_coeff = 1'b1; coefficient_num = 2'd0;
    tick();
    load_coeff = 1'b0;
    reset = 1'b1;
    push(c + 1, F_MW, 64'd0, "mw_reset_in_store");
    push(c + 1, F_COUT, 64'd0, "coeff_out_reset");
    push(c + 1, F_NCS, 64'd0, "ncs_reset");
    tick();
    reset = 1'b0;
    push(c + 2, F_MW, 64'd0, "mw_after_reset");
    push(c + 2, F_COUT, 64'd0, "coeff_out_after_reset");
    tick(); tick();

    for (int k = 0; k < 20 && sb.size() > 0; k++) tick();
    if (sb.size() > 0) begin
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
      errors += sb.size();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
